// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store initiator between the processor datapath and a word-wide data
// memory. Byte, halfword and word requests arrive over a valid/ready
// handshake. Each one becomes a single word read, a single word write, or,
// for sub-word stores, a read-modify-write. Loads return sign- or
// zero-extended lane data. Misaligned, reserved-size and out-of-range
// accesses get an error response and never touch memory.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   req_valid/ready : request handshake; ready only in IDLE
//   req_we          : 1 = store, 0 = load
//   req_size        : 00 byte, 01 half, 10 word, 11 reserved
//   req_signed      : loads only, 1 = sign-extend
//   req_addr        : byte address
//   req_wdata       : right-aligned store data
//   resp_valid/ready: response handshake
//   resp_rdata      : extended load data (0 for stores and errors)
//   resp_err        : misaligned, reserved size or out of range
//   mem_we          : one-cycle write strobe
//   mem_addr        : word index
//   mem_wdata       : word to write
//   mem_rdata       : read data, valid the cycle after a read address
module lsu_mem_ctrl #(
  parameter int unsigned MEM_DEPTH   = 128,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_wbuf;
  logic [31:0] r_mem_addr;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_idx;
  logic [31:0] w_mem_idx;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  // Request decode
  assign w_accept = req_valid && req_ready;
  assign w_idx    = {2'b00, req_addr[31:2]};

  always_comb begin
    w_mem_idx = w_idx;
    if (!CHECK_RANGE) begin
      w_mem_idx = w_idx % MEM_DEPTH;
    end
  end

  always_comb begin
    w_err = 1'b0;
    unique case (req_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = req_addr[0];
      2'b10:   w_err = (req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
    if (CHECK_RANGE && (w_idx >= MEM_DEPTH)) begin
      w_err = 1'b1;
    end
  end

  // Lane extraction and store merge, both little-endian
  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = mem_rdata;
    unique case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = mem_rdata;
    unique case (r_size)
      2'b00:   w_merge[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      2'b01:   w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
      default: w_merge = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = !reset;
        if (w_accept) begin
          if (w_err) begin
            w_next = RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            w_next = WR;
          end else begin
            w_next = RD;
          end
        end
      end
      RD:  w_next = CAP;
      CAP: w_next = r_we ? WR : RESP;
      WR: begin
        mem_we = !reset;
        w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture and datapath. The word index is loaded at accept so
  // mem_addr is already correct during RD/WR and holds elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_wbuf       <= '0;
      r_mem_addr   <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we         <= req_we;
            r_size       <= req_size;
            r_signed     <= req_signed;
            r_lane       <= req_addr[1:0];
            r_wdata      <= req_wdata[15:0];
            r_resp_rdata <= '0;
            r_resp_err   <= w_err;
            if (!w_err) begin
              r_mem_addr <= w_mem_idx;
              if (req_we && (req_size == 2'b10)) begin
                r_wbuf <= req_wdata;
              end
            end
          end
        end
        CAP: begin
          if (r_we) begin
            r_wbuf <= w_merge;
          end else begin
            r_resp_rdata <= w_ext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_wbuf;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule
